// File: rtl/blctrl_scheduler_if.sv
// Command and data stream bundle between the
// BL-Ctrl scheduler and the shared i2c_master.
interface blctrl_scheduler_if;
  logic [6:0] cmd_address;
  logic       cmd_write;
  logic       cmd_stop;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] data_tdata;
  logic       data_tvalid;
  logic       data_tlast;
  logic       data_tready;
  logic       i2c_busy;
  logic       missed_ack;

  modport master (
    output cmd_address,
    output cmd_write,
    output cmd_stop,
    output cmd_valid,
    input  cmd_ready,
    output data_tdata,
    output data_tvalid,
    output data_tlast,
    input  data_tready,
    input  i2c_busy,
    input  missed_ack
  );

  modport slave (
    input  cmd_address,
    input  cmd_write,
    input  cmd_stop,
    input  cmd_valid,
    output cmd_ready,
    input  data_tdata,
    input  data_tvalid,
    input  data_tlast,
    output data_tready,
    output i2c_busy,
    output missed_ack
  );
endinterface

// File: rtl/blctrl_scheduler.sv
// Periodic sweep of up to 8 BL-Ctrl ESCs, one
// single-byte I2C write per enabled motor.
module blctrl_scheduler #(
  parameter logic [6:0]  BASE_ADDR      = 7'h29,
  parameter int unsigned REFRESH_CYCLES = 20000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      master_enable,
  input  logic [7:0]                motor_enable,
  input  logic [63:0]               target_speed_flat,
  blctrl_scheduler_if.master        bus,
  output logic [7:0]                ack_err,
  output logic                      sweep_done,
  output logic                      overrun,
  output logic                      timeout_err
);

  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    CMD,
    DATA,
    WAIT_DONE,
    NEXT,
    DONE
  } state_t;

  state_t        state;
  logic [RW-1:0] ref_cnt;
  logic          tick_pending;
  logic [2:0]    idx;
  logic [TW-1:0] to_cnt;
  logic [1:0]    wait_cnt;
  logic          miss_seen;
  logic [6:0]    addr_q;
  logic [7:0]    data_q;
  logic          cmd_valid_q;
  logic          data_valid_q;

  logic          tick;
  logic          active;
  logic          to_hit;
  logic [7:0]    speed_sel;

  assign tick   = master_enable &&
                  (ref_cnt == RW'(REFRESH_CYCLES - 1));
  assign active = (state == CMD) ||
                  (state == DATA) ||
                  (state == WAIT_DONE);
  assign to_hit = active &&
                  (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // motor 0 sits in the top byte
  assign speed_sel = target_speed_flat[{~idx, 3'b000} +: 8];

  assign bus.cmd_address = addr_q;
  assign bus.cmd_write   = cmd_valid_q;
  assign bus.cmd_stop    = cmd_valid_q;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.data_tdata  = data_q;
  assign bus.data_tvalid = data_valid_q;
  assign bus.data_tlast  = data_valid_q;

  // Refresh timebase, parked at zero while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt <= '0;
    end else if (!master_enable || tick) begin
      ref_cnt <= '0;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // Sweep sequencer with registered bus/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      tick_pending <= 1'b0;
      to_cnt       <= '0;
      wait_cnt     <= '0;
      miss_seen    <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      cmd_valid_q  <= 1'b0;
      data_valid_q <= 1'b0;
      ack_err      <= '0;
      sweep_done   <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      sweep_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;

      if (tick) begin
        tick_pending <= 1'b1;
        overrun      <= (state != IDLE);
      end

      if (active) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (bus.missed_ack &&
          (state == DATA || state == WAIT_DONE)) begin
        miss_seen <= 1'b1;
      end

      if (to_hit) begin
        timeout_err  <= 1'b1;
        ack_err[idx] <= 1'b1;
        cmd_valid_q  <= 1'b0;
        data_valid_q <= 1'b0;
        state        <= NEXT;
      end else begin
        unique case (state)
          IDLE: begin
            if (master_enable && tick_pending) begin
              state        <= SELECT;
              idx          <= '0;
              tick_pending <= tick;
            end
          end
          SELECT: begin
            if (!master_enable) begin
              state <= DONE;
            end else if (motor_enable[idx]) begin
              addr_q      <= BASE_ADDR + {4'd0, idx};
              data_q      <= speed_sel;
              cmd_valid_q <= 1'b1;
              to_cnt      <= '0;
              miss_seen   <= 1'b0;
              state       <= CMD;
            end else if (idx == 3'd7) begin
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          CMD: begin
            if (bus.cmd_ready) begin
              cmd_valid_q  <= 1'b0;
              data_valid_q <= 1'b1;
              state        <= DATA;
            end
          end
          DATA: begin
            if (bus.data_tready) begin
              data_valid_q <= 1'b0;
              wait_cnt     <= '0;
              state        <= WAIT_DONE;
            end
          end
          WAIT_DONE: begin
            // busy may lag the data beat by a cycle or two
            if (wait_cnt != 2'd2) begin
              wait_cnt <= wait_cnt + 1'b1;
            end else if (!bus.i2c_busy) begin
              ack_err[idx] <= miss_seen | bus.missed_ack;
              state        <= NEXT;
            end
          end
          NEXT: begin
            if (idx == 3'd7 || !master_enable) begin
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= SELECT;
            end
          end
          DONE: begin
            sweep_done <= 1'b1;
            state      <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_blctrl_scheduler.sv
// Bench for blctrl_scheduler: randomized bus
// responder plus sweep-level reference model.
module tb_blctrl_scheduler;
  localparam int R = 128;
  localparam int T = 16;
  localparam logic [6:0] BASE = 7'h29;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        master_enable = 1'b0;
  logic [7:0]  motor_enable = 8'h00;
  logic [63:0] target_speed_flat = 64'h0;
  logic [7:0]  ack_err;
  logic        sweep_done;
  logic        overrun;
  logic        timeout_err;

  blctrl_scheduler_if bif ();

  blctrl_scheduler #(
    .BASE_ADDR(BASE),
    .REFRESH_CYCLES(R),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .master_enable(master_enable),
    .motor_enable(motor_enable),
    .target_speed_flat(target_speed_flat),
    .bus(bif),
    .ack_err(ack_err),
    .sweep_done(sweep_done),
    .overrun(overrun),
    .timeout_err(timeout_err)
  );

  // Clock
  always #5 clk = ~clk;

  int nvec = 0;
  int nfail = 0;

  logic [7:0]  stall_mask = 8'h00;
  bit          data_stall = 1'b0;
  bit          miss_en = 1'b0;
  int          miss_idx = 0;
  int          dly_max = 0;
  int          busy_max = 0;
  bit          mutate = 1'b0;
  bit          drop = 1'b0;
  logic [14:0] got_q[$];
  logic [7:0]  model_err = 8'h00;

  int          ph;
  int          dly;
  int          bcnt;
  bit          first_b;
  logic [6:0]  cur_addr;

  int          lat;
  int          done_cyc;
  int          n_sd;
  int          n_ov;
  int          n_to;
  int          n_stall;
  logic [63:0] old_flat;
  logic [63:0] new_flat;

  function automatic int idx_of(input logic [6:0] a);
    logic [6:0] d;
    d = a - BASE;
    return int'(d[2:0]);
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // i2c_master stand-in: random ready delays and busy time
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0;
      dly = 0;
      bcnt = 0;
      first_b = 1'b0;
      got_q.delete();
      bif.cmd_ready = 1'b0;
      bif.data_tready = 1'b0;
      bif.i2c_busy = 1'b0;
      bif.missed_ack = 1'b0;
    end else begin
      bif.missed_ack = 1'b0;
      case (ph)
        0: begin
          bif.data_tready = 1'b0;
          bif.i2c_busy = 1'b0;
          if (bif.cmd_valid &&
              !stall_mask[idx_of(bif.cmd_address)]) begin
            if (dly == 0) begin
              bif.cmd_ready = 1'b1;
              cur_addr = bif.cmd_address;
              dly = $urandom_range(dly_max, 0);
              ph = 1;
            end else begin
              dly--;
            end
          end
        end
        1: begin
          bif.cmd_ready = 1'b0;
          if (bif.data_tvalid && !data_stall) begin
            if (dly == 0) begin
              bif.data_tready = 1'b1;
              got_q.push_back({cur_addr, bif.data_tdata});
              bcnt = $urandom_range(busy_max, 0);
              first_b = 1'b1;
              ph = 2;
            end else begin
              dly--;
            end
          end
        end
        default: begin
          bif.data_tready = 1'b0;
          if (first_b) begin
            bif.missed_ack = miss_en &&
                             (idx_of(cur_addr) == miss_idx);
            first_b = 1'b0;
          end
          if (bcnt > 0) begin
            bif.i2c_busy = 1'b1;
            bcnt--;
          end else begin
            bif.i2c_busy = 1'b0;
            dly = $urandom_range(dly_max, 0);
            ph = 0;
          end
        end
      endcase
    end
  end

  task automatic run(input int n_done);
    int cyc;
    cyc = 0;
    lat = -1;
    done_cyc = -1;
    n_sd = 0;
    n_ov = 0;
    n_to = 0;
    n_stall = 0;
    old_flat = target_speed_flat;
    new_flat = target_speed_flat;
    while (n_sd < n_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bif.cmd_valid && lat < 0) begin
        lat = cyc;
        if (mutate) begin
          new_flat = {$urandom, $urandom};
          target_speed_flat = new_flat;
        end
        if (drop) master_enable = 1'b0;
      end
      if (bif.cmd_valid &&
          stall_mask[idx_of(bif.cmd_address)]) n_stall++;
      if (sweep_done) begin
        n_sd++;
        done_cyc = cyc;
      end
      if (overrun) n_ov++;
      if (timeout_err) n_to++;
    end
  endtask

  task automatic check_sweep(input string tag,
                             input bit chk_lat,
                             input int exp_ov);
    logic [14:0] exp_q[$];
    logic [14:0] g;
    logic [63:0] src;
    logic [7:0]  sp;
    int first;
    int n_exp_to;
    first = -1;
    n_exp_to = 0;
    for (int i = 0; i < 8; i++) begin
      if (!motor_enable[i]) continue;
      if (first < 0) first = i;
      else if (drop) continue;
      src = (mutate && i != first) ? new_flat : old_flat;
      sp = 8'(src >> (56 - 8 * i));
      if (stall_mask[i]) begin
        n_exp_to++;
        model_err[i] = 1'b1;
      end else begin
        exp_q.push_back({7'(BASE + i), sp});
        model_err[i] = miss_en && (miss_idx == i);
      end
    end
    chk({tag, ".n_txn"}, got_q.size(), exp_q.size());
    foreach (exp_q[k]) begin
      g = (k < got_q.size()) ? got_q[k] : 15'bx;
      chk({tag, ".txn"}, g, exp_q[k]);
    end
    chk({tag, ".sweeps"}, n_sd, 1);
    chk({tag, ".ack_err"}, ack_err, model_err);
    chk({tag, ".timeouts"}, n_to, n_exp_to);
    chk({tag, ".stall_cyc"}, n_stall, T * n_exp_to);
    chk({tag, ".overrun"}, n_ov, exp_ov);
    if (chk_lat)
      chk({tag, ".latency"}, lat,
          (first < 0) ? -1 : R + 2 + first);
    got_q.delete();
  endtask

  task automatic sweep(input string tag, input bit chk_lat);
    master_enable = 1'b1;
    run(1);
    master_enable = 1'b0;
    repeat (3) @(negedge clk);
    check_sweep(tag, chk_lat, 0);
  endtask

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Directed sequence with randomized content
  initial begin
    bit seen;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.cmd_valid", bif.cmd_valid, 0);
    chk("rst.cmd_write", bif.cmd_write, 0);
    chk("rst.data_tvalid", bif.data_tvalid, 0);
    chk("rst.data_tlast", bif.data_tlast, 0);
    chk("rst.ack_err", ack_err, 0);
    chk("rst.sweep_done", sweep_done, 0);
    chk("rst.overrun", overrun, 0);
    chk("rst.timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("disabled.cmd_valid", bif.cmd_valid, 0);

    busy_max = 2;
    target_speed_flat = 64'h1011_1213_1415_1617;
    motor_enable = 8'hFF;
    sweep("all", 1'b1);

    target_speed_flat = {$urandom, $urandom};
    motor_enable = 8'b1000_0100;
    sweep("sparse", 1'b1);

    motor_enable = 8'hFF;
    miss_en = 1'b1;
    miss_idx = 1;
    sweep("miss", 1'b1);
    chk("miss.ack_err_02", ack_err, 8'h02);
    miss_en = 1'b0;
    sweep("clean", 1'b1);
    chk("clean.ack_err_00", ack_err, 8'h00);

    dly_max = 2;
    busy_max = 4;
    for (int n = 0; n < 6; n++) begin
      motor_enable = 8'($urandom);
      target_speed_flat = {$urandom, $urandom};
      miss_en = 1'($urandom);
      miss_idx = $urandom_range(7, 0);
      mutate = 1'($urandom);
      sweep("rand", 1'b1);
    end
    mutate = 1'b0;
    miss_en = 1'b0;

    motor_enable = 8'h00;
    sweep("none", 1'b1);
    chk("none.done_cyc", done_cyc, R + 10);

    motor_enable = 8'b0011_0100;
    target_speed_flat = {$urandom, $urandom};
    drop = 1'b1;
    sweep("drop", 1'b1);
    drop = 1'b0;

    motor_enable = 8'h07;
    stall_mask = 8'h02;
    sweep("tmo", 1'b1);

    motor_enable = 8'hFF;
    stall_mask = 8'hFF;
    master_enable = 1'b1;
    run(1);
    check_sweep("ovr1", 1'b1, 1);
    motor_enable = 8'h01;
    stall_mask = 8'h00;
    run(1);
    master_enable = 1'b0;
    check_sweep("ovr2", 1'b0, 0);
    chk("ovr2.ack_err_fe", ack_err, 8'hFE);
    repeat (3) @(negedge clk);

    motor_enable = 8'hFF;
    target_speed_flat = {$urandom, $urandom};
    data_stall = 1'b1;
    master_enable = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      seen = bif.data_tvalid;
    end
    chk("rstdata.reached", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstdata.cmd_valid", bif.cmd_valid, 0);
    chk("rstdata.data_tvalid", bif.data_tvalid, 0);
    chk("rstdata.data_tlast", bif.data_tlast, 0);
    chk("rstdata.cmd_address", bif.cmd_address, 0);
    chk("rstdata.data_tdata", bif.data_tdata, 0);
    chk("rstdata.ack_err", ack_err, 0);
    model_err = 8'h00;
    data_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run(1);
    master_enable = 1'b0;
    repeat (3) @(negedge clk);
    check_sweep("postrst", 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
